mem_walker_stride_nd: RTL
=========================

Name: mem_walker_stride_nd

Overview:
- Self-sequencing N-dimensional strided address generator; next generation of the stride memory walker.
- Holds per-level stride and trip count internally and walks the full loop nest itself, so no external loop controller is needed.
- Emits one address per accepted beat on a valid/ready stream to the memory request path.
- Generalised: configurable depth, signed strides, per-level iteration counts, and output back-pressure.

Parameters:
ADDR_WIDTH, 48, width of base and output address
ADDR_STRIDE_W, 16, width of signed per-level stride
LOOP_ID_W, 3, loop level index width; MAX_LOOPS = 2**LOOP_ID_W levels
LOOP_ITER_W, 16, width of per-level iteration count (stored as count-1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
cfg_loop_v  input  1  write per-level config this cycle
cfg_loop_id  input  LOOP_ID_W  level written; 0 = innermost
cfg_loop_stride  input  ADDR_STRIDE_W  signed stride for level
cfg_loop_iter  input  LOOP_ITER_W  iterations-1 for level
cfg_num_loops  input  LOOP_ID_W  active levels-1; sampled on start
base_addr  input  ADDR_WIDTH  walk base; sampled on start
start  input  1  begin walk (pulse)
busy  output  1  walk in progress (RUN or DONE state)
done  output  1  one-cycle pulse after final address accepted
addr_out  output  ADDR_WIDTH  current address
addr_out_valid  output  1  addr_out valid
addr_out_ready  input  1  consumer accepts addr_out

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy, done, and addr_out_valid all 0; addr_out 0; all stride, iter, and index registers 0.
- Config: in IDLE, cfg_loop_v writes stride[cfg_loop_id] and iter[cfg_loop_id] at the clock edge. cfg_loop_v is ignored while busy. Registers retain their values across walks.
- FSM states: IDLE, RUN, DONE.
- IDLE to RUN: on start. base_addr and cfg_num_loops are latched, all level indices clear, and addr_out is loaded with base_addr. addr_out_valid=1 from the next cycle, i.e. one-cycle latency from start to the first address.
- start while busy: ignored.
- start and cfg_loop_v in the same IDLE cycle: the config write takes effect; the walk uses the pre-write values for that level. Software must not do this.
- Sequence: addr = base + sum over i = 0..NL of idx[i]*sext(stride[i]), where NL = latched cfg_num_loops.
  - Level 0 varies fastest; idx[i] runs 0..iter[i].
  - Total beats = product of (iter[i]+1) over the active levels.
  - Levels above NL are ignored.
- Advance only on a handshake (addr_out_valid & addr_out_ready).
  - Find the lowest level k with idx[k] != iter[k].
  - idx[k]++, and idx[j]=0 for all j<k.
  - New address = level_start[k] + sext(stride[k]).
  - Every level_start[j] for j<=k is set to the new address.
- Incremental arithmetic only: no multipliers. The address must be available next cycle, for one address per cycle sustained throughput with ready held high.
- Back-pressure: while valid & !ready, addr_out and the indices hold stable. Valid never drops before the handshake.
- Last beat: handshake with all active idx[i]==iter[i] moves the FSM to DONE. addr_out_valid=0 in DONE, done=1 for exactly one cycle, busy=1 in DONE, then IDLE.
- Arithmetic: stride is sign-extended to ADDR_WIDTH; addition wraps modulo 2^ADDR_WIDTH with no overflow flag.
- Degenerate walk (all active iter=0): exactly one address, then DONE.
- busy=1 from the cycle after start until the cycle after done.
- Reset asserted mid-walk: outputs clear immediately. After release, the block is in IDLE and needs full reconfiguration.

Test Plan:
- 1-D walk: num_loops=0, L0 stride=4 iter=3, base=0x100, ready=1 -> addr 0x100, 0x104, 0x108, 0x10C on consecutive cycles; done pulses the cycle after the 0x10C handshake.
- 2-D walk: L0 stride=1 iter=2, L1 stride=0x10 iter=1, base=0 -> addr 0x0, 0x1, 0x2, 0x10, 0x11, 0x12; 6 beats, then done.
- Back-pressure: rerun the 2-D walk with ready randomly low (~50%) -> same 6-address sequence; addr_out stable while stalled; no drops or duplicates.
- Negative stride and wrap: L0 stride=0xFFFC (-4) iter=2, base=0x2 -> addr 0x000000000002, 0xFFFFFFFFFFFE, 0xFFFFFFFFFFFA.
- Control corners, each checked separately:
  - start and cfg_loop_v pulsed mid-walk -> no effect on the sequence.
  - All 8 levels with iter=0 -> single address base_addr, then done.
  - Upper levels beyond num_loops configured non-zero -> ignored.
- Reset mid-walk: assert reset during beat 3 of the 2-D walk -> valid, busy, and done are 0 asynchronously; after release and reprogramming, a fresh walk matches scenario 2.

Source files
------------

// File: rtl/mem_walker_stride_nd.sv
// N-level strided address walker: one address per accepted beat, level 0 fastest, incremental adds only.
// Latency: first address 1 cycle after start; backpressure: addr/indices hold while valid & !ready.
module mem_walker_stride_nd #(
    parameter int ADDR_WIDTH    = 48,
    parameter int ADDR_STRIDE_W = 16,
    parameter int LOOP_ID_W     = 3,
    parameter int LOOP_ITER_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_loop_v,
    input  logic [LOOP_ID_W-1:0]     cfg_loop_id,
    input  logic [ADDR_STRIDE_W-1:0] cfg_loop_stride,
    input  logic [LOOP_ITER_W-1:0]   cfg_loop_iter,
    input  logic [LOOP_ID_W-1:0]     cfg_num_loops,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_WIDTH-1:0]    addr_out,
    output logic                     addr_out_valid,
    input  logic                     addr_out_ready
);
    localparam int MAX_LOOPS = 1 << LOOP_ID_W;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t                   state_q, state_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     valid_q, valid_d;
    logic [LOOP_ID_W-1:0]     num_loops_q, num_loops_d;

    // Programmed config persists across walks; the working copy is snapshotted on start.
    logic [ADDR_STRIDE_W-1:0] cfg_stride_q [MAX_LOOPS];
    logic [ADDR_STRIDE_W-1:0] cfg_stride_d [MAX_LOOPS];
    logic [LOOP_ITER_W-1:0]   cfg_iter_q   [MAX_LOOPS];
    logic [LOOP_ITER_W-1:0]   cfg_iter_d   [MAX_LOOPS];
    logic [ADDR_STRIDE_W-1:0] stride_q     [MAX_LOOPS];
    logic [ADDR_STRIDE_W-1:0] stride_d     [MAX_LOOPS];
    logic [LOOP_ITER_W-1:0]   iter_q       [MAX_LOOPS];
    logic [LOOP_ITER_W-1:0]   iter_d       [MAX_LOOPS];
    logic [LOOP_ITER_W-1:0]   idx_q        [MAX_LOOPS];
    logic [LOOP_ITER_W-1:0]   idx_d        [MAX_LOOPS];
    logic [ADDR_WIDTH-1:0]    lvl_start_q  [MAX_LOOPS];
    logic [ADDR_WIDTH-1:0]    lvl_start_d  [MAX_LOOPS];

    logic                     adv_found;
    logic [LOOP_ID_W-1:0]     adv_lvl;
    logic [ADDR_WIDTH-1:0]    next_addr;
    logic                     beat_acc;

    function automatic logic [ADDR_WIDTH-1:0] sext(input logic [ADDR_STRIDE_W-1:0] s);
        return {{(ADDR_WIDTH-ADDR_STRIDE_W){s[ADDR_STRIDE_W-1]}}, s};
    endfunction

    // Lowest active level that still has iterations left; none means this is the last beat.
    always_comb begin
        adv_found = 1'b0;
        adv_lvl   = '0;
        for (int i = 0; i < MAX_LOOPS; i++) begin
            if (!adv_found && (i <= int'(num_loops_q)) && (idx_q[i] != iter_q[i])) begin
                adv_found = 1'b1;
                adv_lvl   = LOOP_ID_W'(i);
            end
        end
    end

    assign next_addr = lvl_start_q[adv_lvl] + sext(stride_q[adv_lvl]);
    assign beat_acc  = valid_q && addr_out_ready;

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        valid_d      = valid_q;
        num_loops_d  = num_loops_q;
        cfg_stride_d = cfg_stride_q;
        cfg_iter_d   = cfg_iter_q;
        stride_d     = stride_q;
        iter_d       = iter_q;
        idx_d        = idx_q;
        lvl_start_d  = lvl_start_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_loop_v) begin
                    cfg_stride_d[cfg_loop_id] = cfg_loop_stride;
                    cfg_iter_d[cfg_loop_id]   = cfg_loop_iter;
                end
                if (start) begin
                    stride_d    = cfg_stride_q;
                    iter_d      = cfg_iter_q;
                    num_loops_d = cfg_num_loops;
                    for (int i = 0; i < MAX_LOOPS; i++) begin
                        idx_d[i]       = '0;
                        lvl_start_d[i] = base_addr;
                    end
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (beat_acc) begin
                    if (adv_found) begin
                        idx_d[adv_lvl] = idx_q[adv_lvl] + LOOP_ITER_W'(1);
                        for (int j = 0; j < MAX_LOOPS; j++) begin
                            if (j < int'(adv_lvl)) begin
                                idx_d[j] = '0;
                            end
                            if (j <= int'(adv_lvl)) begin
                                lvl_start_d[j] = next_addr;
                            end
                        end
                    end else begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            num_loops_q <= '0;
            for (int i = 0; i < MAX_LOOPS; i++) begin
                cfg_stride_q[i] <= '0;
                cfg_iter_q[i]   <= '0;
                stride_q[i]     <= '0;
                iter_q[i]       <= '0;
                idx_q[i]        <= '0;
                lvl_start_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            valid_q      <= valid_d;
            num_loops_q  <= num_loops_d;
            cfg_stride_q <= cfg_stride_d;
            cfg_iter_q   <= cfg_iter_d;
            stride_q     <= stride_d;
            iter_q       <= iter_d;
            idx_q        <= idx_d;
            lvl_start_q  <= lvl_start_d;
        end
    end

    // Level 0's start always equals the most recently generated address.
    assign addr_out       = lvl_start_q[0];
    assign addr_out_valid = valid_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule
